// File: rtl/beat_sequencer_if.sv
// Panel/controller-side bundle of the beat sequencer: request inputs in,
// beat levels, T3 strobe, ST0 and machine-cycle count out.
interface beat_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             qd;
  logic             step;
  logic             short;
  logic             long;
  logic             stop;
  logic             sst0;
  logic             st0_clr;
  logic             w1;
  logic             w2;
  logic             w3;
  logic             t3;
  logic             st0;
  logic             running;
  logic [CNT_W-1:0] mcycles;

  modport master (
    output qd, step, short, long, stop, sst0, st0_clr,
    input  w1, w2, w3, t3, st0, running, mcycles
  );

  modport slave (
    input  qd, step, short, long, stop, sst0, st0_clr,
    output w1, w2, w3, t3, st0, running, mcycles
  );
endinterface

// File: rtl/beat_sequencer.sv
// Machine-cycle timing generator: one-hot W1/W2/W3 beats of PHASES clocks,
// a T3 strobe in each beat's last phase, the ST0 flag and QD start/stop/step.
module beat_sequencer #(
  parameter int PHASES = 4,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            clr,
  beat_sequencer_if.slave bus
);
  localparam int PW = $clog2(PHASES);

  typedef enum logic [0:0] {
    S_HALT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [2:0]    BEAT_W1 = 3'b001;
  localparam logic [2:0]    BEAT_W2 = 3'b010;
  localparam logic [2:0]    BEAT_W3 = 3'b100;
  localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);

  state_e           state_q, state_d;
  logic [2:0]       beat_q, beat_d;
  logic [2:0]       next_beat_q, next_beat_d;
  logic [2:0]       target_s;
  logic [PW-1:0]    phase_q, phase_d;
  logic             qd_prev_q;
  logic             st0_q, st0_d;
  logic [CNT_W-1:0] mcycles_q, mcycles_d;
  logic             t3_s;
  logic             halt_s;
  logic             start_s;

  // State registers; clr wins over every other input.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_HALT;
      beat_q      <= 3'b000;
      next_beat_q <= BEAT_W1;
      phase_q     <= '0;
      qd_prev_q   <= 1'b1;
      st0_q       <= 1'b0;
      mcycles_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      next_beat_q <= next_beat_d;
      phase_q     <= phase_d;
      qd_prev_q   <= bus.qd;
      st0_q       <= st0_d;
      mcycles_q   <= mcycles_d;
    end
  end

  // Successor beat from the current beat and the T3-sampled short/long requests.
  always_comb begin
    target_s = BEAT_W1;
    case (beat_q)
      BEAT_W1: target_s = bus.short ? BEAT_W1 : BEAT_W2;
      BEAT_W2: target_s = bus.long  ? BEAT_W3 : BEAT_W1;
      BEAT_W3: target_s = BEAT_W1;
      default: target_s = BEAT_W1;
    endcase
  end

  assign t3_s    = (state_q == S_RUN) && (phase_q == PH_LAST);
  assign halt_s  = t3_s && (bus.stop || (bus.step && (target_s == BEAT_W1)));
  assign start_s = bus.qd && !qd_prev_q;

  // Next-state logic: QD edge starts from the saved beat; T3 advances or halts.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    next_beat_d = next_beat_q;
    phase_d     = phase_q;
    st0_d       = st0_q;
    mcycles_d   = mcycles_q;
    case (state_q)
      S_HALT: begin
        if (start_s) begin
          state_d = S_RUN;
          beat_d  = next_beat_q;
          phase_d = '0;
        end else begin
          beat_d  = 3'b000;
        end
      end
      S_RUN: begin
        if (t3_s) begin
          phase_d = '0;
          if (bus.sst0) begin
            st0_d = 1'b1;
          end else if (bus.st0_clr) begin
            st0_d = 1'b0;
          end else begin
            st0_d = st0_q;
          end
          if (target_s == BEAT_W1) begin
            mcycles_d = mcycles_q + CNT_W'(1);
          end else begin
            mcycles_d = mcycles_q;
          end
          // A halted beat parks its successor so the next QD resumes there.
          if (halt_s) begin
            state_d     = S_HALT;
            beat_d      = 3'b000;
            next_beat_d = target_s;
          end else begin
            beat_d      = target_s;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        state_d = S_HALT;
        beat_d  = 3'b000;
        phase_d = '0;
      end
    endcase
  end

  assign bus.w1      = beat_q[0];
  assign bus.w2      = beat_q[1];
  assign bus.w3      = beat_q[2];
  assign bus.t3      = t3_s;
  assign bus.st0     = st0_q;
  assign bus.running = (state_q == S_RUN);
  assign bus.mcycles = mcycles_q;
endmodule

// File: tb/tb_beat_sequencer.sv
// Randomized scoreboard bench for beat_sequencer: a beat-level model predicts
// each beat's identity, ST0 and cycle count; a monitor checks them at every T3.
module tb_beat_sequencer;
  localparam int PHASES = 4;
  localparam int CNT_W  = 8;

  typedef struct {
    int beat;
    int st0;
    int mc;
  } exp_t;

  logic clk;
  logic clr;
  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  int   m_next;
  int   m_st0;
  int   m_mc;

  beat_sequencer_if #(.CNT_W(CNT_W)) bus_if ();

  beat_sequencer #(.PHASES(PHASES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int beat_code();
    case ({bus_if.w3, bus_if.w2, bus_if.w1})
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int successor(input int cur, input int sh, input int lg);
    if (cur == 1) return (sh != 0) ? 1 : 2;
    if (cur == 2) return (lg != 0) ? 3 : 1;
    return 1;
  endfunction

  // Beat-level model update for one completed beat; returns 1 when it halts.
  function automatic int model_beat(input int cur, input int sh, input int lg, input int sp,
                                    input int st, input int s0, input int c0, output int tgt);
    tgt = successor(cur, sh, lg);
    if (s0 != 0) m_st0 = 1;
    else if (c0 != 0) m_st0 = 0;
    if (tgt == 1) m_mc = (m_mc + 1) % (1 << CNT_W);
    if ((sp != 0) || ((st != 0) && (tgt == 1))) begin
      m_next = tgt;
      return 1;
    end
    return 0;
  endfunction

  task automatic push_exp(input int cur);
    exp_t e;
    e.beat = cur;
    e.st0  = m_st0;
    e.mc   = m_mc;
    sb_q.push_back(e);
  endtask

  task automatic run_session(input int step_mode);
    int cur, tgt, halted, sh, lg, sp, s0, c0, nbeats;
    bus_if.step = 1'(step_mode);
    bus_if.qd   = 1'b1;
    @(negedge clk);
    cur = m_next;
    check("start_running", bus_if.running, 1);
    check("start_beat", beat_code(), cur);
    halted = 0;
    nbeats = 0;
    while (halted == 0) begin
      sh = $urandom_range(0, 1);
      lg = $urandom_range(0, 1);
      sp = (($urandom_range(0, 9) == 0) || (nbeats >= 40)) ? 1 : 0;
      s0 = ($urandom_range(0, 3) == 0) ? 1 : 0;
      c0 = ($urandom_range(0, 3) == 0) ? 1 : 0;
      bus_if.short   = 1'(sh);
      bus_if.long    = 1'(lg);
      bus_if.stop    = 1'(sp);
      bus_if.sst0    = 1'(s0);
      bus_if.st0_clr = 1'(c0);
      // A QD pulse while running must be ignored.
      bus_if.qd = ((nbeats > 0) && ($urandom_range(0, 4) == 0)) ? 1'b1 : 1'b0;
      push_exp(cur);
      halted = model_beat(cur, sh, lg, sp, step_mode, s0, c0, tgt);
      cur = tgt;
      nbeats++;
      @(negedge clk);
      bus_if.qd = 1'b0;
      repeat (PHASES - 1) @(negedge clk);
    end
    check("halt_running", bus_if.running, 0);
    check("halt_beats", beat_code(), 0);
    check("halt_st0", bus_if.st0, m_st0);
    check("halt_mcycles", bus_if.mcycles, m_mc);
    bus_if.stop = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  task automatic clr_mid_w3();
    int cur, tgt, halted;
    bus_if.step    = 1'b0;
    bus_if.stop    = 1'b0;
    bus_if.short   = 1'b0;
    bus_if.long    = 1'b1;
    bus_if.sst0    = 1'b1;
    bus_if.st0_clr = 1'b0;
    bus_if.qd      = 1'b1;
    @(negedge clk);
    bus_if.qd = 1'b0;
    cur = m_next;
    while (cur != 3) begin
      push_exp(cur);
      halted = model_beat(cur, 0, 1, 0, 0, 1, 0, tgt);
      cur = tgt;
      repeat (PHASES) @(negedge clk);
    end
    check("w3_reached", beat_code(), 3);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("clr_beats", beat_code(), 0);
    check("clr_t3", bus_if.t3, 0);
    check("clr_st0", bus_if.st0, 0);
    check("clr_running", bus_if.running, 0);
    check("clr_mcycles", bus_if.mcycles, 0);
    clr = 1'b0;
    bus_if.sst0 = 1'b0;
    bus_if.long = 1'b0;
    m_next = 1;
    m_st0  = 0;
    m_mc   = 0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: beat timing every cycle, scoreboard comparison at every T3.
  initial begin
    int   run_cyc;
    exp_t e;
    run_cyc = 0;
    forever begin
      @(negedge clk);
      if (bus_if.running === 1'b1) begin
        check("beat_onehot", $countones({bus_if.w3, bus_if.w2, bus_if.w1}), 1);
        check("t3_timing", bus_if.t3, ((run_cyc % PHASES) == (PHASES - 1)) ? 1 : 0);
        if (bus_if.t3 === 1'b1) begin
          if (sb_q.size() == 0) begin
            check("unexpected_t3", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("sb_beat", beat_code(), e.beat);
            check("sb_st0", bus_if.st0, e.st0);
            check("sb_mcycles", bus_if.mcycles, e.mc);
          end
        end
        run_cyc++;
      end else begin
        check("idle_quiet", {bus_if.w3, bus_if.w2, bus_if.w1, bus_if.t3}, 0);
        run_cyc = 0;
      end
    end
  end

  // Driver: reset with QD held, random sessions, mid-beat clear, final step.
  initial begin
    clr            = 1'b1;
    bus_if.qd      = 1'b1;
    bus_if.step    = 1'b0;
    bus_if.short   = 1'b0;
    bus_if.long    = 1'b0;
    bus_if.stop    = 1'b0;
    bus_if.sst0    = 1'b0;
    bus_if.st0_clr = 1'b0;
    m_next = 1;
    m_st0  = 0;
    m_mc   = 0;
    repeat (3) @(negedge clk);
    check("rst_beats", beat_code(), 0);
    check("rst_t3", bus_if.t3, 0);
    check("rst_st0", bus_if.st0, 0);
    check("rst_running", bus_if.running, 0);
    check("rst_mcycles", bus_if.mcycles, 0);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check("qd_held_no_start", bus_if.running, 0);
    bus_if.qd = 1'b0;
    @(negedge clk);
    run_session(0);
    for (int s = 0; s < 150; s++) begin
      run_session(($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    clr_mid_w3();
    run_session(1);
    run_session(0);
    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
